// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serializes accepted words MSB first into a 4-bit history
// and counts overlapping occurrences of a 4-bit pattern. Scanning halts when
// the match count reaches a nonzero threshold. The halt is held until clr.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   in_valid/in_data  word offered for scanning
//   in_ready          word accepted this cycle (combinational)
//   enable            permits acceptance of new words
//   pattern           target sequence, pattern[3] oldest; latched at accept
//   threshold         match count that halts scanning, 0 = never
//   clr               synchronous clear of count, history, done and sequencer
//   match             one-cycle pulse per detected occurrence
//   match_count       saturating match count
//   done              threshold reached (level)
//   busy              sequencer is shifting a word
module pattern_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             enable,
    input  logic [3:0]       pattern,
    input  logic [CNT_W-1:0] threshold,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             busy
);
    localparam int unsigned      IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word_q, word_nxt;
    logic [3:0]       pat_q, pat_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [3:0]       hist, hist_nxt;
    logic [2:0]       fill, fill_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             match_nxt;
    logic             done_nxt;

    logic             cur_bit;
    logic [3:0]       shifted;
    logic [2:0]       fill_inc;
    logic             hit;
    logic [CNT_W-1:0] count_inc;

    // Result of shifting the currently indexed bit into the history
    assign cur_bit   = word_q[idx];
    assign shifted   = {hist[2:0], cur_bit};
    assign fill_inc  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    assign hit       = (fill_inc == 3'd4) && (shifted == pat_q);
    assign count_inc = (match_count == CNT_MAX) ? CNT_MAX : match_count + CNT_W'(1);

    assign busy = (state == SHIFT);

    // Sequencer next state, handshake and datapath updates
    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        pat_nxt   = pat_q;
        idx_nxt   = idx;
        hist_nxt  = hist;
        fill_nxt  = fill;
        count_nxt = match_count;
        match_nxt = 1'b0;
        done_nxt  = done;
        in_ready  = 1'b0;

        if (clr) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            hist_nxt  = '0;
            fill_nxt  = '0;
            count_nxt = '0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready = enable;
                    if (in_valid && enable) begin
                        word_nxt  = in_data;
                        pat_nxt   = pattern;
                        idx_nxt   = IDX_TOP;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    in_ready = enable && (idx == '0);
                    hist_nxt = shifted;
                    fill_nxt = fill_inc;
                    idx_nxt  = idx - IDX_W'(1);
                    if (hit) begin
                        match_nxt = 1'b1;
                        count_nxt = count_inc;
                    end
                    // Halt wins over a bit-0 accept; the rest of the word is dropped
                    if (hit && (threshold != '0) && (count_inc == threshold)) begin
                        done_nxt  = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = HALT;
                    end else if (idx == '0) begin
                        if (in_valid && enable) begin
                            word_nxt = in_data;
                            pat_nxt  = pattern;
                            idx_nxt  = IDX_TOP;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                HALT: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            word_q      <= '0;
            pat_q       <= '0;
            idx         <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            match       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_q      <= word_nxt;
            pat_q       <= pat_nxt;
            idx         <= idx_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            match_count <= count_nxt;
            match       <= match_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: directed scenarios plus random traffic,
// checked against a bit-queue reference model through a scoreboard.
module tb_pattern_scan_ctrl;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             enable;
    logic [3:0]       pattern;
    logic [CNT_W-1:0] threshold;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;
    logic             busy;

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .enable     (enable),
        .pattern    (pattern),
        .threshold  (threshold),
        .clr        (clr),
        .match      (match),
        .match_count(match_count),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the word as a queue of pending bits, history as an integer
    typedef enum int {M_IDLE, M_SHIFT, M_HALT} mmode_t;
    mmode_t m_mode;
    int     m_bits[$];
    int     m_hist;
    int     m_fill;
    int     m_count;
    int     m_done;
    int     m_pat;

    typedef struct {
        int match;
        int count;
        int done;
        int busy;
    } status_t;
    status_t stat_q[$];
    int      match_q[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_mode  = M_IDLE;
        m_bits.delete();
        m_hist  = 0;
        m_fill  = 0;
        m_count = 0;
        m_done  = 0;
        m_pat   = 0;
    endfunction

    function automatic void m_load(logic [WIDTH-1:0] d, logic [3:0] p);
        m_bits.delete();
        for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(int'(d[i]));
        m_pat  = int'(p);
        m_mode = M_SHIFT;
    endfunction

    // One clock cycle: drive inputs, check in_ready, advance the model
    task automatic cyc(bit v, logic [WIDTH-1:0] d, bit en, logic [3:0] p,
                       logic [CNT_W-1:0] thr, bit c, bit r);
        bit exp_ready;
        bit acc;
        int hit;
        int b;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        enable    = en;
        pattern   = p;
        threshold = thr;
        clr       = c;
        rst       = r;
        #1;
        if (!r) begin
            m_reset();
            check("in_ready_in_reset", int'(in_ready), int'(en && !c));
            stat_q.push_back('{match: 0, count: 0, done: 0, busy: 0});
            return;
        end
        exp_ready = !c && en &&
                    ((m_mode == M_IDLE) || (m_mode == M_SHIFT && m_bits.size() == 1));
        check("in_ready", int'(in_ready), int'(exp_ready));
        acc = v && exp_ready;
        hit = 0;
        if (c) begin
            m_reset();
        end else if (m_mode == M_IDLE) begin
            if (acc) m_load(d, p);
        end else if (m_mode == M_SHIFT) begin
            b      = m_bits.pop_front();
            m_hist = ((m_hist << 1) | b) & 15;
            if (m_fill < 4) m_fill++;
            if (m_fill == 4 && m_hist == m_pat) begin
                hit = 1;
                if (m_count < CNT_MAX) m_count++;
                match_q.push_back(m_count);
                if (int'(thr) != 0 && m_count == int'(thr)) begin
                    m_done = 1;
                    m_mode = M_HALT;
                    m_bits.delete();
                end
            end
            if (m_mode == M_SHIFT && m_bits.size() == 0) begin
                if (acc) m_load(d, p);
                else     m_mode = M_IDLE;
            end
        end
        stat_q.push_back('{match: hit, count: m_count, done: m_done,
                           busy: (m_mode == M_SHIFT) ? 1 : 0});
    endtask

    task automatic idle(int n, logic [3:0] p, logic [CNT_W-1:0] thr);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, p, thr, 1'b0, 1'b1);
    endtask

    task automatic clear_pulse();
        cyc(1'b0, '0, 1'b1, 4'd0, '0, 1'b1, 1'b1);
    endtask

    // Monitor: compares every registered output cycle and each match pulse
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("match", int'(match), s.match);
                check("match_count", int'(match_count), s.count);
                check("done", int'(done), s.done);
                check("busy", int'(busy), s.busy);
                if (match) begin
                    if (match_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL match_event: got unexpected pulse, expected none (t=%0t)", $time);
                    end else begin
                        check("match_event_count", int'(match_count), match_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [CNT_W-1:0] thr;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        enable    = 1'b0;
        pattern   = '0;
        threshold = '0;
        clr       = 1'b0;
        m_reset();

        // Reset state
        cyc(1'b0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 4'd0, '0, 1'b0, 1'b0);
        idle(2, 4'd0, '0);

        // Single word 0xDA, pattern 1101: two overlapping-window matches
        cyc(1'b1, 8'hDA, 1'b1, 4'b1101, '0, 1'b0, 1'b1);
        idle(10, 4'b1101, '0);
        check("dir_da_count", int'(match_count), 2);
        clear_pulse();

        // Back-to-back 0xFF words, pattern 1111: 13 matches, no gap
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'hFF, 1'b1, 4'b1111, '0, 1'b0, 1'b1);
        idle(10, 4'b1111, '0);
        check("dir_ff_count", int'(match_count), 13);
        clear_pulse();

        // Match spanning a word boundary
        cyc(1'b1, 8'h01, 1'b1, 4'b1101, '0, 1'b0, 1'b1);
        idle(10, 4'b1101, '0);
        cyc(1'b1, 8'hA0, 1'b1, 4'b1101, '0, 1'b0, 1'b1);
        idle(10, 4'b1101, '0);
        check("dir_span_count", int'(match_count), 1);
        clear_pulse();

        // Threshold 1 halts after the first occurrence and holds until clr
        cyc(1'b1, 8'hDA, 1'b1, 4'b1101, 8'd1, 1'b0, 1'b1);
        idle(6, 4'b1101, 8'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hDA, 1'b1, 4'b1101, 8'd1, 1'b0, 1'b1);
        check("dir_halt_done", int'(done), 1);
        check("dir_halt_count", int'(match_count), 1);
        check("dir_halt_ready", int'(in_ready), 0);
        clear_pulse();
        idle(2, 4'b1101, 8'd1);
        check("dir_clr_count", int'(match_count), 0);
        check("dir_clr_done", int'(done), 0);

        // 40 zero words, pattern 0000: count saturates, match keeps pulsing
        for (int i = 0; i < 1 + 8 * 39; i++) cyc(1'b1, 8'h00, 1'b1, 4'b0000, '0, 1'b0, 1'b1);
        idle(5, 4'b0000, '0);
        check("dir_sat_match", int'(match), 1);
        idle(5, 4'b0000, '0);
        check("dir_sat_count", int'(match_count), CNT_MAX);
        clear_pulse();

        // Reset mid-word; only post-reset bits contribute
        cyc(1'b1, 8'hFF, 1'b1, 4'b1101, '0, 1'b0, 1'b1);
        idle(5, 4'b1101, '0);
        cyc(1'b0, '0, 1'b1, 4'b1101, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 4'b1101, '0, 1'b0, 1'b0);
        idle(1, 4'b1101, '0);
        cyc(1'b1, 8'hD0, 1'b1, 4'b1101, '0, 1'b0, 1'b1);
        idle(10, 4'b1101, '0);
        check("dir_rst_count", int'(match_count), 1);
        clear_pulse();

        // Random traffic with threshold changes, clears and resets
        thr = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3)
                thr = ($urandom_range(0, 9) < 4) ? '0 : CNT_W'($urandom_range(1, 12));
            cyc($urandom_range(0, 99) < 70, WIDTH'($urandom), $urandom_range(0, 99) < 90,
                4'($urandom), thr, $urandom_range(0, 99) < 2, !($urandom_range(0, 999) < 4));
        end
        idle(12, 4'd0, '0);
        @(negedge clk);
        #2;
        check("match_events_left", match_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
